uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver for the crypto datapath's UART link; the receive-side counterpart of the block that serialises bytes onto `TxD`. It samples the `RxD` pin at mid-bit and recovers frames of start bit, 8 data bits LSB-first, even-parity bit and stop bit. For each completed frame it presents one byte with a single-cycle `valid` strobe and per-frame error flags. Its output feeds the byte-stream front end of the cipher cores.

## Interface
- `freq`, default 347: bit period minus one, in `clk` cycles. One bit lasts `freq+1` cycles. Legal range is 3..511.
- `clk`  input  1  system clock; everything is on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `RxD`  input  1  serial line. It is asynchronous to `clk` and idles high.
- `data`  output  8  last received byte. Held until the next frame completes.
- `valid`  output  1  one-cycle strobe meaning `data`, `parity_err` and `frame_err` have just been updated.
- `parity_err`  output  1  1 when the received parity bit differs from the XOR of the 8 received data bits. Held with `data`.
- `frame_err`  output  1  1 when the stop bit was sampled low. Held with `data`.
- `busy`  output  1  1 whenever the state is not IDLE.

## Operation
- **Synchroniser.** `RxD` passes through a 2-flop synchroniser to produce `rx_s`, plus one more register `rx_d`. Both are reset to 1.
- **Start edge.** A start edge is the condition `rx_s==0 && rx_d==1`. It is only acted on in IDLE.
- **States:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a start edge, go to START and load `cnt <= 0`.
  - START: when `cnt == freq>>1` (floor), sample `rx_s`. If it is 1, this was a glitch: return to IDLE with no output. If it is 0, go to DATA with `cnt <= 0` and `bitidx <= 0`.
  - DATA: when `cnt == freq`, shift `rx_s` into `shreg[bitidx]` (LSB first) and set `cnt <= 0`. After bit index 7, go to PARITY.
  - PARITY: when `cnt == freq`, capture the parity bit, set `cnt <= 0`, go to STOP.
  - STOP: when `cnt == freq`, sample the stop bit and go to IDLE.
- **Counter.** `cnt` is 9 bits. Outside the sample points listed above it increments by 1 every cycle and never wraps in normal use.
- **Output update.** In the cycle after the stop sample:
  - `data <= shreg`
  - `parity_err <= ^shreg ^ parity_bit`
  - `frame_err <= ~stop_bit`
  - `valid <= 1` for exactly one cycle.
- **Errors do not suppress output.** A frame with parity or framing error still pulses `valid`; the flags report the fault.
- **No flow control.** There is no backpressure. A consumer that misses `valid` loses the byte, and the next frame overwrites it.
- **Framing error recovery.**
  - If the stop bit was low and the line stays low, no new falling edge exists. The receiver waits in IDLE until the line goes high and then falls again.
  - A break condition therefore yields exactly one frame with `frame_err=1`.

## Timing
- **Reset values** (take effect immediately on `rst`):
  - `data=0`, `valid=0`, `parity_err=0`, `frame_err=0`, `busy=0`
  - state IDLE, `cnt=0`, `shreg=0`, `rx_s=rx_d=1`
- **Reset mid-frame** aborts the frame, produces no `valid`, and yields a clean IDLE.
- **Synchroniser latency.** A pin transition reaches `rx_s` 2 cycles later.
- **Sample timeline.** Let E be the cycle in which the start edge is detected, and h = `freq>>1`.
  - Start-bit sample: cycle E+1+h.
  - Data bit k sample: E+1+h+(k+1)(freq+1).
  - Parity sample: E+1+h+9(freq+1).
  - Stop sample: E+1+h+10(freq+1).
  - `valid` high: E+2+h+10(freq+1).
- **Back-to-back frames.** The state returns to IDLE in the cycle after the stop sample, about half a bit before the nominal end of the stop bit. A start edge immediately following the stop bit is therefore detected; no idle gap is required.
- **`busy`** rises in cycle E+1 and falls in the same cycle that `valid` rises. For a glitch it falls the cycle after the start sample.
- **Baud tolerance.** Mid-bit sampling tolerates about ±4% accumulated rate error over 11 bits.

## Test plan
Run all scenarios with `freq=15` (16 cycles/bit), so h=7 and `valid` arrives 169 cycles after E.

1. **Good frame.** Send 0xA5 with parity bit 0 and stop bit 1. Expect exactly one `valid`, at E+169, with `data=0xA5`, `parity_err=0`, `frame_err=0`; `busy` high for cycles E+1..E+168.
2. **Parity error.** Send 0x01 with parity bit 0 (wrong). Expect `valid` with `data=0x01`, `parity_err=1`, `frame_err=0`.
3. **Framing error.** Send 0x3C with correct parity 0 and stop bit 0, then hold the line low for 40 cycles, then high. Expect one `valid` with `frame_err=1`, `data=0x3C`, and no second `valid`.
4. **Glitch.** Drive `RxD` low for 4 cycles, then high. Expect no `valid`, `busy` high for 8 cycles, then IDLE. A following 0x5A frame is received correctly.
5. **Reset mid-frame.** Assert `rst` during data bit 3 of a frame. Expect all outputs 0 immediately and no `valid` for the aborted frame. A subsequent 0xC3 frame yields `data=0xC3` with no errors.
6. **Back-to-back.** Send 0x00 then 0xFF with the second start bit directly after the first stop bit. Expect two `valid` pulses exactly 176 cycles apart (11 bits × 16), with `data` 0x00 then 0xFF and both error flags 0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8E1 serial receiver with mid-bit sampling, parity/framing flags and a one-cycle valid strobe.
module uart_rx #(
  parameter int freq = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [8:0] full = 9'(freq);
  localparam logic [8:0] half = 9'(freq >> 1);
  state_t state, next;
  logic [8:0] cnt;
  logic [2:0] bitidx;
  logic [7:0] shreg;
  logic       par, rx_m, rx_s, rx_d, hit, edge_seen;
  assign hit = cnt == (state == START ? half : full);
  assign edge_seen = !rx_s && rx_d;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = edge_seen ? START : IDLE;
      START:   next = hit ? (rx_s ? IDLE : DATA) : START;
      DATA:    next = (hit && bitidx == 3'd7) ? PARITY : DATA;
      PARITY:  next = hit ? STOP : PARITY;
      STOP:    next = hit ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_m, rx_s, rx_d} <= 3'b111;
      cnt <= '0;
      bitidx <= '0;
      shreg <= '0;
      par <= 1'b0;
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      {rx_m, rx_s, rx_d} <= {RxD, rx_m, rx_s};
      valid <= 1'b0;
      cnt <= (state == IDLE || hit) ? 9'd0 : cnt + 9'd1;
      if (state == START) bitidx <= '0;
      if (state == DATA && hit) begin
        shreg[bitidx] <= rx_s;
        bitidx <= bitidx + 3'd1;
      end
      if (state == PARITY && hit) par <= rx_s;
      // Outputs land one cycle after the stop sample, together with the strobe.
      if (state == STOP && hit) begin
        data <= shreg;
        parity_err <= ^shreg ^ par;
        frame_err <= ~rx_s;
        valid <= 1'b1;
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked by a queue-based scoreboard with a separate monitor.
module tb_uart_rx;
  logic clk = 0, rst = 0, RxD = 1;
  logic [7:0] data;
  logic valid, parity_err, frame_err, busy;
  uart_rx #(.freq(15)) dut (
    .clk(clk), .rst(rst), .RxD(RxD), .data(data), .valid(valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {logic [7:0] d; logic pe; logic fe; int t;} exp_t;
  exp_t q[$];
  exp_t e;
  int vt[$];
  int cyc = 0, checks = 0, fails = 0, busy_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (!rst && valid) begin
      vt.push_back(cyc);
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid: got data %0d with nothing expected (cycle %0d)", data, cyc);
      end else begin
        e = q.pop_front();
        chk("data", data, e.d);
        chk("parity_err", parity_err, e.pe);
        chk("frame_err", frame_err, e.fe);
        chk("valid_cycle", cyc, e.t);
      end
    end
  task automatic tick(int n);
    repeat (n) begin
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask
  task automatic idle(int n);
    RxD = 1;
    tick(n);
  endtask
  // 16 cycles per bit; the line change takes 2 cycles to reach the edge detector, then 169 to valid.
  task automatic send(logic [7:0] b, logic par, logic stop);
    q.push_back('{b, (^b) ^ par, ~stop, cyc + 171});
    RxD = 0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      tick(16);
    end
    RxD = par;
    tick(16);
    RxD = stop;
    tick(16);
  endtask
  initial begin
    logic [7:0] b;
    logic par, stop;
    #2 rst = 1;
    #1;
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    idle(10);
    busy_cnt = 0;
    send(8'hA5, 1'b0, 1'b1);
    chk("good_busy_cycles", busy_cnt, 168);
    idle(20);
    send(8'h01, 1'b0, 1'b1);
    idle(20);
    send(8'h3C, 1'b0, 1'b0);
    RxD = 0;
    tick(40);
    idle(200);
    chk("break_pending", q.size(), 0);
    busy_cnt = 0;
    RxD = 0;
    tick(4);
    idle(30);
    chk("glitch_busy_cycles", busy_cnt, 8);
    send(8'h5A, 1'b0, 1'b1);
    idle(200);
    b = 8'h5F;
    RxD = 0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      RxD = b[i];
      tick(16);
    end
    RxD = b[3];
    tick(8);
    rst = 1;
    #1;
    chk("midrst_data", data, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_parity_err", parity_err, 0);
    chk("midrst_frame_err", frame_err, 0);
    chk("midrst_busy", busy, 0);
    RxD = 1;
    tick(3);
    rst = 0;
    idle(20);
    send(8'hC3, 1'b0, 1'b1);
    idle(200);
    send(8'h00, 1'b0, 1'b1);
    send(8'hFF, 1'b0, 1'b1);
    idle(200);
    chk("b2b_count", vt.size(), 7);
    if (vt.size() >= 2) chk("b2b_spacing", vt[vt.size()-1] - vt[vt.size()-2], 176);
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom);
      par = ($urandom_range(0, 3) == 0) ? ~^b : ^b;
      stop = $urandom_range(0, 4) != 0;
      send(b, par, stop);
      idle($urandom_range(stop ? 0 : 2, 20));
    end
    idle(200);
    chk("final_pending", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
